// File: rtl/stopwatch_command_decoder.sv
// stopwatch_command_decoder
//
// Command front end of the UART stopwatch. Pops ASCII bytes from a
// first-word-fall-through receive FIFO and decodes them into stopwatch
// controls. Report requests (o_start) are rate-limited by a lockout
// down-counter so a new request never lands while the transmitter is
// still sending its frame.
//
// State table:
//   IDLE    | waiting for a byte; pops and latches the FIFO head
//   DECODE  | acts on the latched byte for exactly one cycle
//   WAIT_TX | report pending until the lockout counter reaches zero
//
// Ports:
//   i_clk       clock
//   i_reset     asynchronous, active-high reset
//   i_rx_empty  receive FIFO empty flag
//   i_rx_data   receive FIFO head byte (valid while i_rx_empty = 0)
//   o_rx_rd     FIFO pop strobe
//   o_clr       one-cycle clear pulse
//   o_go        level: 1 = counting
//   o_up        level: 1 = count up, 0 = count down
//   o_start     one-cycle report request to the transmitter
//   o_cmd_err   one-cycle pulse for an unrecognised byte
module stopwatch_command_decoder #(
  parameter int LOCKOUT = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_empty,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_rd,
  output logic       o_clr,
  output logic       o_go,
  output logic       o_up,
  output logic       o_start,
  output logic       o_cmd_err
);

  localparam int CW = $clog2(LOCKOUT + 1);
  localparam logic [CW-1:0] LOAD = CW'(LOCKOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_WAIT_TX = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go_q, go_d;
  logic          up_q, up_d;

  // Clearing bit 5 folds lower-case letters onto upper-case; no other
  // byte aliases onto a command letter this way.
  logic [7:0] cmd_uc;
  logic       is_c, is_g, is_p, is_u, is_d, is_r, is_known;
  logic       cnt_zero;

  always_comb begin
    cmd_uc   = cmd_q & 8'hDF;
    is_c     = (cmd_uc == 8'h43);
    is_g     = (cmd_uc == 8'h47);
    is_p     = (cmd_uc == 8'h50);
    is_u     = (cmd_uc == 8'h55);
    is_d     = (cmd_uc == 8'h44);
    is_r     = (cmd_uc == 8'h52);
    is_known = is_c | is_g | is_p | is_u | is_d | is_r;
    cnt_zero = (cnt_q == '0);
  end

  // Pulses depend only on registered state, command and counter, so they
  // are free of input-driven glitches. The pop strobe is the one output
  // that must follow the FIFO flag within the cycle.
  always_comb begin
    o_rx_rd   = (state_q == S_IDLE) && !i_rx_empty && !i_reset;
    o_clr     = (state_q == S_DECODE) && is_c;
    o_cmd_err = (state_q == S_DECODE) && !is_known;
    o_start   = cnt_zero &&
                (((state_q == S_DECODE) && is_r) || (state_q == S_WAIT_TX));
    o_go      = go_q;
    o_up      = up_q;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    go_d    = go_q;
    up_d    = up_q;

    case (state_q)
      S_IDLE: begin
        if (!i_rx_empty) begin
          cmd_d   = i_rx_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_g) go_d = 1'b1;
        if (is_p) go_d = 1'b0;
        if (is_u) up_d = 1'b1;
        if (is_d) up_d = 1'b0;
        if (is_r && !cnt_zero) state_d = S_WAIT_TX;
        else                   state_d = S_IDLE;
      end
      S_WAIT_TX: begin
        if (cnt_zero) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reloading on the pulse itself makes the next pulse land exactly
    // LOCKOUT cycles later when the counter is the only limit.
    if (o_start)       cnt_d = LOAD;
    else if (!cnt_zero) cnt_d = cnt_q - CW'(1);
    else               cnt_d = cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'h00;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      up_q    <= up_d;
    end
  end

endmodule

// File: doc/stopwatch_command_decoder.md
# stopwatch_command_decoder

Command front end of the UART stopwatch. It pops received ASCII bytes from the UART receive FIFO and decodes them into stopwatch controls: clear, go/pause and count direction. It also issues report requests, as `o_start`, to the stopwatch transmit interface. Report requests are rate-limited so that a request is never issued while the transmitter is still emitting its 8-byte frame.

## Interface
Parameters:
- `LOCKOUT`, default 8: minimum number of cycles between consecutive `o_start` pulses. Legal range is LOCKOUT >= 1. The default matches the transmitter's 8-cycle frame.

Ports:
- `i_clk`, input, 1 bit: clock.
- `i_reset`, input, 1 bit: reset, asynchronous, active-high. This is already decided.
- `i_rx_empty`, input, 1 bit: receive FIFO empty flag.
- `i_rx_data`, input, 8 bits: receive FIFO head byte. The FIFO is first-word-fall-through, so this byte is valid whenever `i_rx_empty` = 0.
- `o_rx_rd`, output, 1 bit: FIFO pop strobe, one cycle per byte.
- `o_clr`, output, 1 bit: one-cycle pulse that clears the stopwatch count.
- `o_go`, output, 1 bit: level signal; 1 = counting.
- `o_up`, output, 1 bit: level signal; 1 = count up, 0 = count down.
- `o_start`, output, 1 bit: one-cycle report request to the transmit interface.
- `o_cmd_err`, output, 1 bit: one-cycle pulse when the decoded byte is not a recognised command.

## Operation
Commands are case-insensitive:
- `C`/`c` (0x43/0x63): pulse `o_clr`. No effect on `o_go` or `o_up`.
- `G`/`g` (0x47/0x67): `o_go` <- 1.
- `P`/`p` (0x50/0x70): `o_go` <- 0.
- `U`/`u` (0x55/0x75): `o_up` <- 1.
- `D`/`d` (0x44/0x64): `o_up` <- 0.
- `R`/`r` (0x52/0x72): report request, subject to the lockout.
- Any other byte, including CR and LF: pulse `o_cmd_err`, then discard the byte.

State machine, 3 states:
- **IDLE**
  - If `i_rx_empty` = 0: latch `i_rx_data` into the command register, assert `o_rx_rd` (combinationally, this cycle) and go to DECODE.
  - Otherwise: stay in IDLE, with `o_rx_rd` = 0.
- **DECODE** (always exactly one cycle). Act on the latched byte:
  - `o_clr`, `o_cmd_err` and `o_start` are combinational Mealy pulses asserted during this cycle.
  - `o_go` and `o_up` are registered and change on the clock edge that ends DECODE.
  - For R with lockout counter = 0: assert `o_start` and go to IDLE.
  - For R with lockout counter != 0: go to WAIT_TX, with no `o_start` yet.
  - For all other bytes: go to IDLE.
- **WAIT_TX**
  - No FIFO pop occurs; the FIFO backs up, and no bytes are lost.
  - When the lockout counter = 0: assert `o_start` and go to IDLE.

Lockout counter:
- Width is clog2(LOCKOUT+1).
- Loaded with LOCKOUT-1 on every cycle in which `o_start` = 1.
- Otherwise decrements by 1 while nonzero, saturating at 0.
- Result: the next `o_start` can occur no earlier than LOCKOUT cycles after the previous one.
- `o_start` is never asserted outside DECODE or WAIT_TX.

Simultaneous events:
- A byte is never popped in the same cycle as another pop, DECODE or WAIT_TX. There is at most one `o_rx_rd` per two cycles.
- The FIFO becoming non-empty while the block is in DECODE or WAIT_TX is ignored until IDLE.

Reset (asynchronous, takes effect immediately at any point in any state):
- State -> IDLE; command register = 0x00; lockout counter = 0.
- `o_go` = 0, `o_up` = 1.
- `o_clr`, `o_start`, `o_cmd_err` and `o_rx_rd` = 0.
- A report pending in WAIT_TX is dropped.
- A byte popped before reset is lost. This is acceptable.

## Timing
- Byte latency: a byte at the FIFO head in IDLE at cycle N is popped in N. Its pulse output (`o_clr`/`o_start`/`o_cmd_err`) appears in N+1. Level output changes (`o_go`/`o_up`) are visible from N+2.
- Throughput: one command per 2 cycles when not locked out.
- With back-to-back R commands, `o_start` pulses are spaced exactly LOCKOUT cycles apart when LOCKOUT >= 2. They are spaced 2 cycles apart (the throughput limit) when LOCKOUT = 1.
- All outputs are glitch-free relative to `i_clk`. The pulses are decoded only from registered state and registered command.

## Test plan
- **Reset values.** Assert `i_reset` mid-WAIT_TX -> immediately `o_go`=0, `o_up`=1, all pulses 0, state IDLE. After release with an empty FIFO -> no `o_start`.
- **Level commands.** Feed "G", "d", "P", "U" -> `o_go` sequence 1, 1, 0, 0 and `o_up` sequence 1, 0, 0, 1. Each change is visible 2 cycles after its pop, and there is exactly one `o_rx_rd` per byte.
- **Clear and errors.** Feed "c", 0x0A, "x" -> one `o_clr` pulse, then two `o_cmd_err` pulses. `o_go` and `o_up` are unchanged.
- **Report lockout** (LOCKOUT=8). Feed "RRR" back to back -> `o_start` at cycles t, t+8 and t+16. No byte is popped while in WAIT_TX. Exactly three `o_rx_rd` pulses occur.
- **Mixed traffic.** Feed "R", "G", "R" -> the G takes effect before the second `o_start`. The second `o_start` is held until 8 cycles after the first.
- **Empty stall.** Hold `i_rx_empty`=1 for 100 cycles -> no `o_rx_rd`, no pulses, and the levels are held.
